// File: rtl/nibble_serial_sub_if.sv
// Handshake and data bundle for the nibble-serial subtractor.
// The master side supplies operands and accepts results; the slave side is the subtractor.
interface nibble_serial_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d_out;
    logic             borrow_out;
    logic             ovf_out;
    logic             z_out;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, d_out, borrow_out, ovf_out, z_out
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, d_out, borrow_out, ovf_out, z_out
    );
endinterface

// File: rtl/nibble_serial_sub.sv
// Nibble-serial subtractor: D = A - B, one 4-bit nibble per clock, LSB nibble first.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | in_ready high, waiting for operands
// RUN    | one nibble of A + ~B + carry per clock, NIB clocks total
// DONE   | out_valid high, result and flags held until out_ready
//
// The operand registers shift right by one nibble per RUN cycle, so the
// active nibble is always bits [3:0]. The partial result shifts in from the
// top and is only copied to d_out on the last nibble, so d_out never shows a
// half-finished value.
module nibble_serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    nibble_serial_sub_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             z_q, z_d;

    logic [4:0]       nib_sum;
    logic [WIDTH-1:0] res_final;

    // One nibble of A + ~B + carry, and the result as it stands after it.
    always_comb begin
        nib_sum   = {1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + {4'b0000, carry_q};
        res_final = {nib_sum[3:0], res_q[WIDTH-1:4]};
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            z_q      <= z_d;
        end
    end

    // Next-state, nibble sequencing and flag capture.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        z_d      = z_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    res_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                res_d   = res_final;
                carry_d = nib_sum[4];
                if (cnt_q == CNT_LAST) begin
                    // a_q[3]/b_q[3] are the operand sign bits on the last nibble.
                    d_d      = res_final;
                    borrow_d = ~nib_sum[4];
                    ovf_d    = (a_q[3] != b_q[3]) & (nib_sum[3] != a_q[3]);
                    z_d      = (res_final == '0);
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake flags come straight from the state; results from registers.
    always_comb begin
        bus.in_ready   = (state_q == S_IDLE);
        bus.out_valid  = (state_q == S_DONE);
        bus.d_out      = d_q;
        bus.borrow_out = borrow_q;
        bus.ovf_out    = ovf_q;
        bus.z_out      = z_q;
    end
endmodule

// File: tb/tb_nibble_serial_sub.sv
module tb_nibble_serial_sub;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    nibble_serial_sub_if #(.WIDTH(16)) bus16 ();
    nibble_serial_sub_if #(.WIDTH(8))  bus8 ();

    nibble_serial_sub #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    nibble_serial_sub #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic ov(input int w);
        return (w == 8) ? bus8.out_valid : bus16.out_valid;
    endfunction
    function automatic logic ir(input int w);
        return (w == 8) ? bus8.in_ready : bus16.in_ready;
    endfunction
    function automatic logic [15:0] dout(input int w);
        return (w == 8) ? {8'h00, bus8.d_out} : bus16.d_out;
    endfunction
    function automatic logic [2:0] flags(input int w);
        return (w == 8) ? {bus8.borrow_out, bus8.ovf_out, bus8.z_out}
                        : {bus16.borrow_out, bus16.ovf_out, bus16.z_out};
    endfunction

    task automatic set_in(input int w, input logic iv, input logic [15:0] a, input logic [15:0] b);
        if (w == 8) begin
            bus8.in_valid = iv; bus8.a_in = a[7:0]; bus8.b_in = b[7:0];
        end else begin
            bus16.in_valid = iv; bus16.a_in = a; bus16.b_in = b;
        end
    endtask
    task automatic set_or(input int w, input logic r);
        if (w == 8) bus8.out_ready = r;
        else        bus16.out_ready = r;
    endtask

    // Reference: plain integer arithmetic on w-bit values.
    task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] d, output logic [2:0] f);
        longint ua, ub, sa, sb, diff, m;
        m  = (longint'(1) << w);
        ua = longint'(a) % m;
        ub = longint'(b) % m;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        diff = sa - sb;
        d = 16'((ua - ub + m) % m);
        f[2] = (ua < ub);
        f[1] = (diff < -(m / 2)) || (diff >= m / 2);
        f[0] = (((ua - ub + m) % m) == 0);
    endtask

    task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b, input int stall);
        logic [15:0] exp_d;
        logic [2:0]  exp_f;
        int n;
        model(w, a, b, exp_d, exp_f);
        @(negedge clk);
        chk("in_ready_idle", 32'(ir(w)), 32'd1);
        set_in(w, 1'b1, a, b);
        set_or(w, 1'b0);
        @(negedge clk);
        set_in(w, 1'b0, 16'($urandom), 16'($urandom));
        n = 0;
        while (!ov(w) && n < 20) begin
            chk("in_ready_busy", 32'(ir(w)), 32'd0);
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(w / 4));
        chk("d_out", 32'(dout(w)), 32'(exp_d));
        chk("flags_bvz", 32'(flags(w)), 32'(exp_f));
        for (int i = 0; i < stall; i++) begin
            set_in(w, 1'b1, 16'($urandom), 16'($urandom));
            @(negedge clk);
            chk("stall_valid", 32'(ov(w)), 32'd1);
            chk("stall_in_ready", 32'(ir(w)), 32'd0);
            chk("stall_d", 32'(dout(w)), 32'(exp_d));
            chk("stall_flags", 32'(flags(w)), 32'(exp_f));
        end
        set_in(w, 1'b0, 16'h0000, 16'h0000);
        set_or(w, 1'b1);
        @(negedge clk);
        set_or(w, 1'b0);
        chk("out_valid_drop", 32'(ov(w)), 32'd0);
        chk("in_ready_back", 32'(ir(w)), 32'd1);
    endtask

    initial begin
        logic [15:0] da [6];
        logic [15:0] db [6];
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        set_in(16, 1'b0, 16'h0, 16'h0); set_or(16, 1'b0);
        set_in(8, 1'b0, 16'h0, 16'h0);  set_or(8, 1'b0);
        da = '{16'h1234, 16'h1000, 16'h0000, 16'h8000, 16'h5A5A, 16'hBEEF};
        db = '{16'h0234, 16'h0001, 16'h0001, 16'h0001, 16'h5A5A, 16'h0000};

        #12;
        chk("rst_in_ready16", 32'(ir(16)), 32'd1);
        chk("rst_out_valid16", 32'(ov(16)), 32'd0);
        chk("rst_d16", 32'(dout(16)), 32'd0);
        chk("rst_flags16", 32'(flags(16)), 32'd0);
        chk("rst_in_ready8", 32'(ir(8)), 32'd1);
        chk("rst_out_valid8", 32'(ov(8)), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) do_op(16, da[i], db[i], 0);

        // Backpressure with new operands offered during DONE.
        do_op(16, 16'h4321, 16'h1111, 10);
        repeat (3) begin
            @(negedge clk);
            chk("no_capture_valid", 32'(ov(16)), 32'd0);
            chk("no_capture_ready", 32'(ir(16)), 32'd1);
        end

        // Reset two cycles into RUN aborts the operation.
        @(negedge clk);
        set_in(16, 1'b1, 16'h7777, 16'h1111);
        @(negedge clk);
        set_in(16, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_in_ready", 32'(ir(16)), 32'd1);
        chk("abort_out_valid", 32'(ov(16)), 32'd0);
        chk("abort_d", 32'(dout(16)), 32'd0);
        chk("abort_flags", 32'(flags(16)), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(ov(16)), 32'd0);
        end
        do_op(16, 16'h0003, 16'h0005, 0);

        // in_valid together with rst: reset wins.
        @(negedge clk);
        rst = 1'b1;
        set_in(16, 1'b1, 16'h9999, 16'h1234);
        @(negedge clk);
        rst = 1'b0;
        set_in(16, 1'b0, 16'h0, 16'h0);
        repeat (6) begin
            @(negedge clk);
            chk("rst_iv_no_valid", 32'(ov(16)), 32'd0);
            chk("rst_iv_ready", 32'(ir(16)), 32'd1);
        end

        // out_ready in IDLE has no effect; then random sweeps.
        set_or(16, 1'b1);
        @(negedge clk);
        set_or(16, 1'b0);
        for (int i = 0; i < 1000; i++)
            do_op(16, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
        for (int i = 0; i < 1000; i++)
            do_op(8, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), int'($urandom_range(0, 3)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
